otter_ctrl_fsm: RTL and testbench

Parametrised multicycle control FSM for the OTTER MCU. It replaces the fixed-timing CU_FSM and adds three things: configurable memory read latency, multiple prioritised and maskable interrupt sources with pending latches, and illegal-opcode flagging. It sits between instruction memory and the datapath and drives the PC, register-file and memory strobes. CU_DCDR still produces the mux selects.

---
 rtl/otter_ctrl_pkg.sv | 34 +++
 rtl/otter_intr_pend.sv | 58 +++++
 rtl/otter_ctrl_fsm.sv | 144 ++++++++++++++
 tb/tb_otter_ctrl_fsm.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_ctrl_pkg.sv
// rtl/otter_ctrl_pkg.sv - shared types and opcode constants for the OTTER control FSM
// Contents: state_t (controller states), OPC_* RV32I major opcodes,
//           opc_writes_rd() for single-cycle opcodes that retire with a register write.
package otter_ctrl_pkg;

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        WB    = 3'd3,
        INTR  = 3'd4
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Opcodes that finish in one EXEC cycle and write the register file.
    function automatic logic opc_writes_rd(input logic [6:0] opc);
        case (opc)
            OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_SYSTEM: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/otter_intr_pend.sv
// rtl/otter_intr_pend.sv - interrupt edge detect, pending latches and priority encoder
// Ports: clk, rst (sync, active-low); intr (request lines), intr_mask (1 = enabled);
//        clr_en/clr_idx clear one pending bit; any_pend = some enabled bit pending;
//        pend_idx = lowest enabled pending index (0 when none).
module otter_intr_pend #(
    parameter int N_INTR = 4,
    parameter int CW     = (N_INTR > 1) ? $clog2(N_INTR) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_INTR-1:0] intr,
    input  logic [N_INTR-1:0] intr_mask,
    input  logic              clr_en,
    input  logic [CW-1:0]     clr_idx,
    output logic              any_pend,
    output logic [CW-1:0]     pend_idx
);

    logic [N_INTR-1:0] intr_q;
    logic [N_INTR-1:0] pending;
    logic [N_INTR-1:0] set_vec;
    logic [N_INTR-1:0] clr_vec;
    logic [N_INTR-1:0] enabled;

    always_comb begin
        set_vec = intr & ~intr_q;
        clr_vec = '0;
        for (int i = 0; i < N_INTR; i++) begin
            clr_vec[i] = clr_en && (clr_idx == CW'(i));
        end
    end

    // Clear first, then OR in new edges: a set in the same cycle as its
    // clear leaves the bit pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            intr_q  <= '0;
            pending <= '0;
        end else begin
            intr_q  <= intr;
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

    assign enabled  = pending & intr_mask;
    assign any_pend = |enabled;

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        pend_idx = '0;
        for (int i = N_INTR - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                pend_idx = CW'(i);
            end
        end
    end

endmodule

// File: rtl/otter_ctrl_fsm.sv
// rtl/otter_ctrl_fsm.sv - multicycle OTTER control FSM with memory latency and interrupts
// Ports: clk, rst (sync, active-low); opcode = ir[6:0]; intr/intr_mask/mie interrupt inputs;
//        pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset datapath strobes;
//        int_taken/int_cause serviced interrupt; illegal_op unrecognised opcode pulse.
module otter_ctrl_fsm
    import otter_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int N_INTR  = 4,
    parameter int CW      = (N_INTR > 1) ? $clog2(N_INTR) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode,
    input  logic [N_INTR-1:0] intr,
    input  logic [N_INTR-1:0] intr_mask,
    input  logic              mie,
    output logic              pcWrite,
    output logic              regWrite,
    output logic              memWE2,
    output logic              memRDEN1,
    output logic              memRDEN2,
    output logic              reset,
    output logic              int_taken,
    output logic [CW-1:0]     int_cause,
    output logic              illegal_op
);

    localparam int              CNTW     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(MEM_LAT - 1);

    state_t          state;
    state_t          state_d;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_d;
    logic            lat_done;
    logic            any_pend;
    logic [CW-1:0]   pend_idx;
    logic            clr_en;
    logic            take_intr;

    otter_intr_pend #(
        .N_INTR (N_INTR),
        .CW     (CW)
    ) u_intr_pend (
        .clk       (clk),
        .rst       (rst),
        .intr      (intr),
        .intr_mask (intr_mask),
        .clr_en    (clr_en),
        .clr_idx   (pend_idx),
        .any_pend  (any_pend),
        .pend_idx  (pend_idx)
    );

    assign lat_done  = (cnt == CNT_LAST);
    assign take_intr = mie & any_pend;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // cnt_d defaults to 0, so the counter only advances while a memory
    // phase is still waiting and restarts at 0 on every state change.
    always_comb begin
        state_d    = state;
        cnt_d      = '0;
        pcWrite    = 1'b0;
        regWrite   = 1'b0;
        memWE2     = 1'b0;
        memRDEN1   = 1'b0;
        memRDEN2   = 1'b0;
        reset      = 1'b0;
        int_taken  = 1'b0;
        int_cause  = '0;
        illegal_op = 1'b0;
        clr_en     = 1'b0;

        case (state)
            INIT: begin
                reset   = 1'b1;
                state_d = FETCH;
            end

            FETCH: begin
                memRDEN1 = 1'b1;
                if (lat_done) begin
                    state_d = EXEC;
                end else begin
                    cnt_d = cnt + CNTW'(1);
                end
            end

            EXEC: begin
                if (opcode == OPC_LOAD) begin
                    memRDEN2 = 1'b1;
                    if (lat_done) begin
                        state_d = WB;
                    end else begin
                        cnt_d = cnt + CNTW'(1);
                    end
                end else begin
                    // Single-cycle EXEC is the instruction boundary.
                    pcWrite = 1'b1;
                    if (opcode == OPC_STORE) begin
                        memWE2 = 1'b1;
                    end else if (opc_writes_rd(opcode)) begin
                        regWrite = 1'b1;
                    end else if (opcode != OPC_BRANCH) begin
                        illegal_op = 1'b1;
                    end
                    state_d = take_intr ? INTR : FETCH;
                end
            end

            WB: begin
                regWrite = 1'b1;
                pcWrite  = 1'b1;
                state_d  = take_intr ? INTR : FETCH;
            end

            INTR: begin
                // The mask may have changed since the boundary; only clear
                // a bit that is still enabled and pending.
                pcWrite   = 1'b1;
                int_taken = 1'b1;
                int_cause = pend_idx;
                clr_en    = any_pend;
                state_d   = FETCH;
            end

            default: begin
                state_d = INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_otter_ctrl_fsm.sv
// tb/tb_otter_ctrl_fsm.sv - scoreboard bench for otter_ctrl_fsm
module tb_otter_ctrl_fsm;

    localparam int ML  = 3;
    localparam int NI  = 4;
    localparam int CWB = 2;

    localparam int K_LOAD   = 0;
    localparam int K_STORE  = 1;
    localparam int K_BRANCH = 2;
    localparam int K_REG    = 3;
    localparam int K_ILL    = 4;

    typedef struct packed {
        logic [31:0]    cyc;
        logic           rst_o;
        logic           pc_w;
        logic           reg_w;
        logic           mem_we;
        logic           ill;
        logic           taken;
        logic [CWB-1:0] cause;
        logic [7:0]     rd1;
        logic [7:0]     rd2;
    } ev_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [6:0]     opcode;
    logic [NI-1:0]  intr;
    logic [NI-1:0]  intr_mask;
    logic           mie;
    logic           pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset_o;
    logic           int_taken, illegal_op;
    logic [CWB-1:0] int_cause;

    otter_ctrl_fsm #(
        .MEM_LAT (ML),
        .N_INTR  (NI)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .intr       (intr),
        .intr_mask  (intr_mask),
        .mie        (mie),
        .pcWrite    (pcWrite),
        .regWrite   (regWrite),
        .memWE2     (memWE2),
        .memRDEN1   (memRDEN1),
        .memRDEN2   (memRDEN2),
        .reset      (reset_o),
        .int_taken  (int_taken),
        .int_cause  (int_cause),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    logic [31:0] cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model state ----------------
    ev_t           exp_q[$];
    logic [NI-1:0] m_pend = '0;
    logic [NI-1:0] m_prev = '0;
    logic [NI-1:0] m_clr  = '0;
    int            rd1_acc = 0;
    int            rd2_acc = 0;
    int            mode = 0;
    logic          done = 1'b0;
    logic [6:0]    legal_ops [10] = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h13,
                                      7'h37, 7'h17, 7'h6f, 7'h67, 7'h73};

    function automatic int op_kind(input logic [6:0] op);
        case (op)
            7'h03:   return K_LOAD;
            7'h23:   return K_STORE;
            7'h63:   return K_BRANCH;
            7'h33, 7'h13, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h73: return K_REG;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int lowest(input logic [NI-1:0] v);
        for (int i = 0; i < NI; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic string fmt(input ev_t e);
        return $sformatf("cyc=%0d rst=%b pc=%b rw=%b we=%b ill=%b tk=%b cause=%0d rd1=%0d rd2=%0d",
                         e.cyc, e.rst_o, e.pc_w, e.reg_w, e.mem_we, e.ill, e.taken, e.cause, e.rd1, e.rd2);
    endfunction

    task automatic push_ev(input logic r, input logic pc, input logic rw, input logic we,
                           input logic il, input logic tk, input int cs);
        ev_t e;
        e.cyc    = cyc;
        e.rst_o  = r;
        e.pc_w   = pc;
        e.reg_w  = rw;
        e.mem_we = we;
        e.ill    = il;
        e.taken  = tk;
        e.cause  = CWB'(cs);
        e.rd1    = 8'(rd1_acc);
        e.rd2    = 8'(rd2_acc);
        exp_q.push_back(e);
        rd1_acc = 0;
        rd2_acc = 0;
    endtask

    // Advance one clock; the model absorbs the intr value seen during the cycle just ended.
    task automatic step();
        @(posedge clk);
        #1;
        m_pend = (m_pend & ~m_clr) | (intr & ~m_prev);
        m_prev = intr;
        m_clr  = '0;
    endtask

    task automatic pick_inputs();
        if (mode == 1) begin
            for (int i = 0; i < NI; i++) if ($urandom_range(0, 11) == 0) intr[i] = ~intr[i];
            if ($urandom_range(0, 19) == 0) intr_mask = NI'($urandom);
            if ($urandom_range(0, 29) == 0) mie = ~mie;
        end
    endtask

    task automatic do_reset(input int n);
        rst  = 1'b0;
        intr = '0;
        repeat (n) @(posedge clk);
        #1;
        m_pend = '0;
        m_prev = '0;
        m_clr  = '0;
        rst    = 1'b1;
        push_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
    endtask

    // One instruction: fetch takes ML cycles, a load adds ML read cycles and a WB cycle,
    // everything else retires in one EXEC cycle. abort_k >= 0 pulls rst low in that cycle.
    task automatic run_instr(input logic [6:0] op, input int abort_k);
        int   kind;
        int   len;
        logic take;
        logic [NI-1:0] en;
        kind = op_kind(op);
        len  = (kind == K_LOAD) ? 2 * ML + 1 : ML + 1;
        take = 1'b0;
        opcode = op;
        for (int k = 0; k < len; k++) begin
            pick_inputs();
            if (k == abort_k) begin
                do_reset(3);
                return;
            end
            if (k < ML) rd1_acc++;
            else if (kind == K_LOAD && k < 2 * ML) rd2_acc++;
            if (k == len - 1) begin
                push_ev(1'b0, 1'b1, kind == K_LOAD || kind == K_REG, kind == K_STORE,
                        kind == K_ILL, 1'b0, 0);
                take = mie && ((m_pend & intr_mask) != '0);
            end
            step();
        end
        if (take) begin
            pick_inputs();
            en = m_pend & intr_mask;
            push_ev(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, lowest(en));
            if (en != '0) m_clr[lowest(en)] = 1'b1;
            step();
        end
    endtask

    task automatic run_ops(input logic [6:0] op, input int n);
        for (int i = 0; i < n; i++) run_instr(op, -1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0] rop;
        int         r;
        rst = 1'b0; opcode = '0; intr = '0; intr_mask = '1; mie = 1'b1;
        do_reset(3);

        mode = 0;
        run_ops(7'h33, 2);
        run_ops(7'h03, 1);
        run_ops(7'h23, 1);
        run_ops(7'h63, 1);
        run_ops(7'h7f, 1);
        run_ops(7'h6f, 1);

        intr = 4'b1010;                 // causes 1 then 3 at successive boundaries
        run_ops(7'h13, 3);

        intr = '0;
        run_ops(7'h33, 1);
        intr_mask = 4'b0111;
        intr = 4'b1000;                 // bit 3 masked: stays pending
        run_ops(7'h33, 2);
        intr_mask = 4'b1111;
        run_ops(7'h33, 2);

        intr = '0;
        run_ops(7'h33, 1);
        intr = 4'b0100;                 // level held: only one service
        run_ops(7'h33, 6);
        intr = '0;
        run_ops(7'h33, 1);

        mie = 1'b0;
        intr = 4'b0100;
        run_ops(7'h03, 2);
        mie = 1'b1;
        run_ops(7'h33, 2);

        intr = '0;
        mie = 1'b0;
        run_ops(7'h33, 1);
        intr = 4'b0001;
        run_ops(7'h33, 1);
        intr = '0;
        run_instr(7'h03, ML + 1);       // reset on the second memRDEN2 cycle
        mie = 1'b1;
        intr_mask = 4'b1111;
        run_ops(7'h33, 2);

        mode = 1;
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 11);
            if (r < 10) rop = legal_ops[r];
            else        rop = 7'($urandom);
            run_instr(rop, -1);
        end

        rst  = 1'b0;
        done = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   m_rd1  = 0;
    int   m_rd2  = 0;
    logic fin    = 1'b0;
    ev_t  act;
    ev_t  expv;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (memRDEN1) m_rd1++;
            if (memRDEN2) m_rd2++;
            if (pcWrite || reset_o) begin
                act.cyc    = cyc;
                act.rst_o  = reset_o;
                act.pc_w   = pcWrite;
                act.reg_w  = regWrite;
                act.mem_we = memWE2;
                act.ill    = illegal_op;
                act.taken  = int_taken;
                act.cause  = int_cause;
                act.rd1    = 8'(m_rd1);
                act.rd2    = 8'(m_rd2);
                m_rd1 = 0;
                m_rd2 = 0;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL event: got %s, required no event", fmt(act));
                end else begin
                    expv = exp_q.pop_front();
                    if (act !== expv) begin
                        n_fail++;
                        $display("FAIL event: got %s, required %s", fmt(act), fmt(expv));
                    end
                end
            end else begin
                n_cmp++;
                if (regWrite || memWE2 || illegal_op || int_taken || int_cause != '0) begin
                    n_fail++;
                    $display("FAIL stray @%0d: got rw=%b we=%b ill=%b tk=%b cause=%0d, required all 0",
                             cyc, regWrite, memWE2, illegal_op, int_taken, int_cause);
                end
            end
        end
        if (done && !fin) begin
            fin = 1'b1;
            n_cmp++;
            if (exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL drain: got %0d events still expected, required 0", exp_q.size());
            end
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion by %0t, required completion", $time);
        $fatal(1);
    end

endmodule
